// File: rtl/spike_rate_decoder_pkg.sv
// Shared definitions for the spike-rate decoder: command encodings, FSM states
// and the saturating increment used by the per-channel counters.
package snn_decode_pkg;

  localparam logic [1:0] CMD_STOP  = 2'b00;
  localparam logic [1:0] CMD_LEFT  = 2'b01;
  localparam logic [1:0] CMD_RIGHT = 2'b10;
  localparam logic [1:0] CMD_FWD   = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] count, input logic [31:0] max);
    logic [31:0] res;
    if (count >= max) begin
      res = max;
    end else begin
      res = count + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_counter.sv
// Saturating per-channel spike counter; count_next_o already includes this
// cycle's spike so the window-end capture sees the final value.
module spike_counter
  import snn_decode_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_next_o
);

  localparam logic [CNT_W-1:0] MAX_C = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [31:0]      inc_s;

  // Next count: saturating add when enabled and a spike is present
  always_comb begin
    inc_s = sat_inc(32'(count_q), 32'(MAX_C));
    if (en_i && inc_i) begin
      count_d = inc_s[CNT_W-1:0];
    end else begin
      count_d = count_q;
    end
  end

  // Count register; clear at window end starts the next window from zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (en_i && clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_next_o = count_d;

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder: counts spikes per channel over WINDOW enabled
// cycles and turns the Left/Right rates into a steering command on valid/ready.
module spike_rate_decoder
  import snn_decode_pkg::*;
#(
  parameter int unsigned EXCNUM   = 2,
  parameter int unsigned WINDOW   = 256,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned THRESH   = 4,
  parameter int unsigned DEADBAND = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [EXCNUM-1:0]       spike_in,
  output logic [EXCNUM*CNT_W-1:0] rate_count,
  output logic [1:0]              cmd,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    overrun
);

  localparam int unsigned      WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

  state_e                    state_q;
  logic [WIN_W-1:0]          win_q;
  logic [EXCNUM*CNT_W-1:0]   rate_q;
  logic [1:0]                cmd_q;
  logic                      valid_q;
  logic                      overrun_q;

  logic [EXCNUM*CNT_W-1:0]   next_s;
  logic                      win_end_s;
  logic [CNT_W-1:0]          l_s;
  logic [CNT_W-1:0]          r_s;
  logic [CNT_W:0]            diff_s;
  logic [1:0]                dec_s;

  assign win_end_s = en && (win_q == WIN_LAST);

  for (genvar gi = 0; gi < EXCNUM; gi++) begin : g_cnt
    spike_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i        (clk),
      .rst_i        (rst),
      .en_i         (en),
      .inc_i        (spike_in[gi]),
      .clear_i      (win_end_s),
      .count_next_o (next_s[gi*CNT_W +: CNT_W])
    );
  end

  assign l_s = next_s[0 +: CNT_W];
  assign r_s = next_s[CNT_W +: CNT_W];

  // Steering decision on the final window counts; difference is one bit wider so it never wraps
  always_comb begin
    if (l_s > r_s) begin
      diff_s = {1'b0, l_s} - {1'b0, r_s};
    end else begin
      diff_s = {1'b0, r_s} - {1'b0, l_s};
    end
    if ((32'(l_s) < 32'(THRESH)) && (32'(r_s) < 32'(THRESH))) begin
      dec_s = CMD_STOP;
    end else if (32'(diff_s) <= 32'(DEADBAND)) begin
      dec_s = CMD_FWD;
    end else if (l_s > r_s) begin
      dec_s = CMD_LEFT;
    end else begin
      dec_s = CMD_RIGHT;
    end
  end

  // Window FSM, result latch and valid/ready handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= '0;
      rate_q    <= '0;
      cmd_q     <= CMD_STOP;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= RUN;
            win_q   <= WIN_ONE;
          end
        end
        RUN: begin
          if (en) begin
            win_q <= win_end_s ? '0 : win_q + WIN_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (win_end_s) begin
        rate_q    <= next_s;
        cmd_q     <= dec_s;
        valid_q   <= 1'b1;
        overrun_q <= valid_q && !cmd_ready;
      end else if (valid_q && cmd_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rate_count = rate_q;
  assign cmd        = cmd_q;
  assign cmd_valid  = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench: two decoders (CNT_W=4 and CNT_W=3, WINDOW=16) share
// stimulus and are compared against a window-level reference model.
module tb_spike_rate_decoder;

  localparam int WIN = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] spike_in = 2'b00;
  logic       cmd_ready = 1'b0;

  logic [7:0] rate4;
  logic [1:0] cmd4;
  logic       valid4, ovr4;
  logic [5:0] rate3;
  logic [1:0] cmd3;
  logic       valid3, ovr3;

  int checks = 0;
  int fails  = 0;

  // reference model state
  int         raw_l, raw_r, win_n;
  bit         exp_valid, exp_ovr;
  logic [7:0] exp_rate4;
  logic [1:0] exp_cmd4;
  logic [5:0] exp_rate3;
  logic [1:0] exp_cmd3;

  always #5 clk = ~clk;

  spike_rate_decoder #(.EXCNUM(2), .WINDOW(WIN), .CNT_W(4), .THRESH(4), .DEADBAND(2)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .rate_count(rate4),
    .cmd(cmd4), .cmd_valid(valid4), .cmd_ready(cmd_ready), .overrun(ovr4)
  );

  spike_rate_decoder #(.EXCNUM(2), .WINDOW(WIN), .CNT_W(3), .THRESH(4), .DEADBAND(2)) dut3 (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .rate_count(rate3),
    .cmd(cmd3), .cmd_valid(valid3), .cmd_ready(cmd_ready), .overrun(ovr3)
  );

  function automatic int clampi(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [1:0] decide(int l, int r);
    int d;
    d = (l > r) ? l - r : r - l;
    if (l < 4 && r < 4) return 2'b00;
    else if (d <= 2) return 2'b11;
    else if (l > r) return 2'b01;
    else return 2'b10;
  endfunction

  task automatic model_reset();
    raw_l = 0; raw_r = 0; win_n = 0;
    exp_valid = 0; exp_ovr = 0;
    exp_rate4 = '0; exp_cmd4 = '0; exp_rate3 = '0; exp_cmd3 = '0;
  endtask

  // one clock: drive inputs, take the edge, advance the model, settle
  task automatic cycle(input bit e, input bit [1:0] sp, input bit rd);
    int l4, r4, l3, r3;
    en = e; spike_in = sp; cmd_ready = rd;
    @(posedge clk);
    exp_ovr = 0;
    if (e) begin
      raw_l += int'(sp[0]); raw_r += int'(sp[1]); win_n++;
    end
    if (e && win_n == WIN) begin
      l4 = clampi(raw_l, 15); r4 = clampi(raw_r, 15);
      l3 = clampi(raw_l, 7);  r3 = clampi(raw_r, 7);
      exp_ovr   = exp_valid && !rd;
      exp_valid = 1;
      exp_rate4 = {4'(r4), 4'(l4)}; exp_cmd4 = decide(l4, r4);
      exp_rate3 = {3'(r3), 3'(l3)}; exp_cmd3 = decide(l3, r3);
      raw_l = 0; raw_r = 0; win_n = 0;
    end else if (exp_valid && rd) begin
      exp_valid = 0;
    end
    #1;
  endtask

  // one full window with nl left and nr right spikes at random positions
  task automatic run_window(input int nl, input int nr, input bit rd);
    bit lp[WIN];
    bit rp[WIN];
    bit t;
    int j;
    for (int i = 0; i < WIN; i++) begin
      lp[i] = (i < nl); rp[i] = (i < nr);
    end
    for (int i = WIN - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = lp[i]; lp[i] = lp[j]; lp[j] = t;
      j = $urandom_range(0, i);
      t = rp[i]; rp[i] = rp[j]; rp[j] = t;
    end
    for (int i = 0; i < WIN; i++) cycle(1'b1, {rp[i], lp[i]}, rd);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({valid4, ovr4, cmd4, rate4, valid3, ovr3, cmd3, rate3} !== 20'd0) begin
      fails++; $display("FAIL reset_init: got %h want 0", {valid4, ovr4, cmd4, rate4, valid3, ovr3, cmd3, rate3});
    end
    rst = 1'b0;
    repeat (5) cycle(1'b1, 2'b11, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({valid4, ovr4, cmd4, rate4, valid3, ovr3, cmd3, rate3} !== 20'd0) begin
      fails++; $display("FAIL reset_async: got %h want 0", {valid4, ovr4, cmd4, rate4, valid3, ovr3, cmd3, rate3});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (WIN) cycle(1'b1, 2'b00, 1'b0);
    checks++;
    if ({valid4, ovr4, cmd4, rate4} !== {1'b1, 1'b0, 2'b00, 8'h00}) begin
      fails++; $display("FAIL reset_fresh_window: got %h want %h", {valid4, ovr4, cmd4, rate4}, {1'b1, 1'b0, 2'b00, 8'h00});
    end
  endtask

  task automatic test_left_dominant();
    cycle(1'b0, 2'b00, 1'b1);
    checks++;
    if (valid4 !== 1'b0) begin
      fails++; $display("FAIL drain_valid: got %b want 0", valid4);
    end
    run_window(10, 3, 1'b0);
    checks++;
    if ({valid4, ovr4, cmd4, rate4} !== {1'b1, 1'b0, 2'b01, 8'h3A}) begin
      fails++; $display("FAIL left_dominant: got %h want %h", {valid4, ovr4, cmd4, rate4}, {1'b1, 1'b0, 2'b01, 8'h3A});
    end
    checks++;
    if ({valid3, cmd3, rate3} !== {exp_valid, exp_cmd3, exp_rate3}) begin
      fails++; $display("FAIL left_dominant_w3: got %h want %h", {valid3, cmd3, rate3}, {exp_valid, exp_cmd3, exp_rate3});
    end
  endtask

  task automatic test_deadband_stop();
    cycle(1'b0, 2'b00, 1'b1);
    run_window(7, 6, 1'b0);
    checks++;
    if ({valid4, cmd4, rate4} !== {1'b1, 2'b11, 8'h67}) begin
      fails++; $display("FAIL deadband: got %h want %h", {valid4, cmd4, rate4}, {1'b1, 2'b11, 8'h67});
    end
    cycle(1'b0, 2'b00, 1'b1);
    run_window(3, 1, 1'b0);
    checks++;
    if ({valid4, cmd4, rate4} !== {1'b1, 2'b00, 8'h13}) begin
      fails++; $display("FAIL stop: got %h want %h", {valid4, cmd4, rate4}, {1'b1, 2'b00, 8'h13});
    end
  endtask

  task automatic test_saturation();
    cycle(1'b0, 2'b00, 1'b1);
    repeat (WIN) cycle(1'b1, 2'b11, 1'b0);
    checks++;
    if ({valid3, cmd3, rate3} !== {1'b1, 2'b11, 6'o77}) begin
      fails++; $display("FAIL saturation_w3: got %h want %h", {valid3, cmd3, rate3}, {1'b1, 2'b11, 6'o77});
    end
    checks++;
    if ({valid4, cmd4, rate4} !== {1'b1, 2'b11, 8'hFF}) begin
      fails++; $display("FAIL saturation_w4: got %h want %h", {valid4, cmd4, rate4}, {1'b1, 2'b11, 8'hFF});
    end
  endtask

  task automatic test_backpressure();
    cycle(1'b0, 2'b00, 1'b1);
    run_window($urandom_range(0, WIN), $urandom_range(0, WIN), 1'b0);
    checks++;
    if ({valid4, ovr4} !== 2'b10) begin
      fails++; $display("FAIL bp_first_end: got %b want 10", {valid4, ovr4});
    end
    run_window($urandom_range(0, WIN), $urandom_range(0, WIN), 1'b0);
    checks++;
    if ({valid4, ovr4, cmd4, rate4, ovr3, rate3} !== {2'b11, exp_cmd4, exp_rate4, 1'b1, exp_rate3}) begin
      fails++; $display("FAIL bp_overrun: got %h want %h", {valid4, ovr4, cmd4, rate4, ovr3, rate3}, {2'b11, exp_cmd4, exp_rate4, 1'b1, exp_rate3});
    end
    cycle(1'b0, 2'b00, 1'b0);
    checks++;
    if ({valid4, ovr4, cmd4, rate4} !== {2'b10, exp_cmd4, exp_rate4}) begin
      fails++; $display("FAIL bp_pulse_width: got %h want %h", {valid4, ovr4, cmd4, rate4}, {2'b10, exp_cmd4, exp_rate4});
    end
    cycle(1'b0, 2'b00, 1'b1);
    checks++;
    if ({valid4, valid3} !== 2'b00) begin
      fails++; $display("FAIL bp_consume: got %b want 00", {valid4, valid3});
    end
  endtask

  task automatic test_en_gaps();
    cycle(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 2 * WIN; i++) begin
      cycle((i % 2) == 0, 2'($urandom_range(0, 3)), 1'b0);
      if (i == 2 * WIN - 3) begin
        checks++;
        if (valid4 !== 1'b0) begin
          fails++; $display("FAIL gap_early_valid: got %b want 0", valid4);
        end
      end
      if (i == 2 * WIN - 2) begin
        checks++;
        if ({valid4, cmd4, rate4, cmd3, rate3} !== {1'b1, exp_cmd4, exp_rate4, exp_cmd3, exp_rate3}) begin
          fails++; $display("FAIL gap_result: got %h want %h", {valid4, cmd4, rate4, cmd3, rate3}, {1'b1, exp_cmd4, exp_rate4, exp_cmd3, exp_rate3});
        end
      end
    end
    for (int i = 0; i < WIN - 1; i++) cycle(1'b1, 2'($urandom_range(0, 3)), 1'b0);
    cycle(1'b1, 2'($urandom_range(0, 3)), 1'b1);
    checks++;
    if ({valid4, ovr4, cmd4, rate4, ovr3, rate3} !== {2'b10, exp_cmd4, exp_rate4, 1'b0, exp_rate3}) begin
      fails++; $display("FAIL end_with_transfer: got %h want %h", {valid4, ovr4, cmd4, rate4, ovr3, rate3}, {2'b10, exp_cmd4, exp_rate4, 1'b0, exp_rate3});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
      checks++;
      if ({valid4, ovr4, valid3, ovr3} !== {exp_valid, exp_ovr, exp_valid, exp_ovr}) begin
        fails++; $display("FAIL rand_flags cyc %0d: got %b want %b", i, {valid4, ovr4, valid3, ovr3}, {exp_valid, exp_ovr, exp_valid, exp_ovr});
      end
      if (exp_valid) begin
        checks++;
        if ({cmd4, rate4, cmd3, rate3} !== {exp_cmd4, exp_rate4, exp_cmd3, exp_rate3}) begin
          fails++; $display("FAIL rand_result cyc %0d: got %h want %h", i, {cmd4, rate4, cmd3, rate3}, {exp_cmd4, exp_rate4, exp_cmd3, exp_rate3});
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_left_dominant();
    test_deadband_stop();
    test_saturation();
    test_backpressure();
    test_en_gaps();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
